// File: rtl/imm_gen_pkg.sv
// Shared types for the pipelined immediate generator: format encoding,
// RV opcodes and the auto-decode helper used by stage 1.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    IMM_NONE   = 3'd0,
    IMM_I      = 3'd1,
    IMM_S      = 3'd2,
    IMM_B      = 3'd3,
    IMM_U      = 3'd4,
    IMM_J      = 3'd5,
    IMM_ISHIFT = 3'd6,
    IMM_ZERO   = 3'd7
  } imm_type_e;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;

  typedef struct packed {
    imm_type_e typ;
    logic      illegal;
  } dec_t;

  typedef struct packed {
    logic [31:0] instr;
    imm_type_e   typ;
    logic        illegal;
  } s1_t;

  function automatic dec_t auto_decode(logic [31:0] instr);
    dec_t d;
    d.typ     = IMM_NONE;
    d.illegal = 1'b0;
    case (instr[6:0])
      OP_LOAD, OP_JALR, OP_SYSTEM: d.typ = IMM_I;
      // funct3 001 (slli) and 101 (srli/srai) share funct3[1:0]=01
      OP_IMM:            d.typ = (instr[13:12] == 2'b01) ? IMM_ISHIFT : IMM_I;
      OP_STORE:          d.typ = IMM_S;
      OP_BRANCH:         d.typ = IMM_B;
      OP_LUI, OP_AUIPC:  d.typ = IMM_U;
      OP_JAL:            d.typ = IMM_J;
      OP_REG, OP_FENCE:  d.typ = IMM_NONE;
      default:           d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: builds the 32-bit signed field for the
// selected format, then sign-extends to XLEN (shift amounts zero-extend).
module imm_extract
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_type_e       typ,
  output logic [XLEN-1:0] imm
);

  logic [31:0] v;
  logic [5:0]  shamt;

  assign shamt = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};

  always_comb begin
    v = '0;
    case (typ)
      IMM_I: v = {{20{instr[31]}}, instr[31:20]};
      IMM_S: v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: v = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: v = {instr[31:12], 12'b0};
      IMM_J: v = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: v = '0;
    endcase
  end

  always_comb begin
    imm = XLEN'($signed(v));
    if (typ == IMM_ISHIFT) imm = XLEN'(shamt);
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage immediate generator (decode, extend) with a combinational
// ready chain for full throughput and a saturating illegal-opcode counter.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [2:0]       imm_type,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe;
  logic            s1_adv, s2_adv;
  s1_t             s1_d, s1_q;
  dec_t            dec;
  logic [XLEN-1:0] ext_imm;

  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign s1_adv    = !vld_pipe[1] || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = vld_pipe[2];

  always_comb begin
    dec = auto_decode(instr);
    s1_d.instr   = instr;
    s1_d.typ     = dec.typ;
    s1_d.illegal = dec.illegal;
    // forced formats bypass opcode decode and are always legal
    if (imm_src != 3'd0) begin
      s1_d.typ     = imm_type_e'(imm_src);
      s1_d.illegal = 1'b0;
    end
  end

  imm_extract #(.XLEN(XLEN)) u_ext (
    .instr (s1_q.instr),
    .typ   (s1_q.typ),
    .imm   (ext_imm)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe    <= '0;
      s1_q        <= '0;
      imm_ext     <= '0;
      imm_type    <= '0;
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      if (s1_adv) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          imm_ext  <= ext_imm;
          imm_type <= s1_q.typ;
          illegal  <= s1_q.illegal;
        end
      end
      if (vld_pipe[2] && out_ready && illegal && (illegal_cnt != '1))
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: expected results are queued at input
// handshake and compared at output handshake.
module tb_imm_gen_pipe;
  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      instr = '0;
  logic [2:0]       imm_src = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  imm_ext;
  logic [2:0]       imm_type;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  imm_gen_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .imm_src(imm_src), .out_valid(out_valid), .out_ready(out_ready),
    .imm_ext(imm_ext), .imm_type(imm_type), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          exp_cnt = 0;
  logic        rand_rdy = 1'b0;
  logic        held = 1'b0;
  logic [31:0] held_imm;
  logic [2:0]  held_typ;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(logic [31:0] ins, logic [2:0] src);
    exp_t e;
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    e.ill = 1'b0;
    e.typ = src;
    if (src == 3'd0) begin
      if (op == 7'h03 || op == 7'h67 || op == 7'h73) e.typ = 3'd1;
      else if (op == 7'h13) e.typ = (f3 == 3'b001 || f3 == 3'b101) ? 3'd6 : 3'd1;
      else if (op == 7'h23) e.typ = 3'd2;
      else if (op == 7'h63) e.typ = 3'd3;
      else if (op == 7'h37 || op == 7'h17) e.typ = 3'd4;
      else if (op == 7'h6F) e.typ = 3'd5;
      else if (op == 7'h33 || op == 7'h0F) e.typ = 3'd0;
      else begin e.typ = 3'd0; e.ill = 1'b1; end
    end
    case (e.typ)
      3'd1: e.imm = 32'($signed(ins) >>> 20);
      3'd2: e.imm = (32'($signed(ins) >>> 20) & ~32'h1F) | {27'd0, ins[11:7]};
      3'd3: e.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd4: e.imm = ins & 32'hFFFF_F000;
      3'd5: e.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      3'd6: e.imm = {27'd0, ins[24:20]};
      default: e.imm = 32'd0;
    endcase
    return e;
  endfunction

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(logic [31:0] ins, logic [2:0] src);
    int k = 0;
    instr = ins; imm_src = src; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    else sb.push_back(model(ins, src));
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || out_valid) && k < 200) begin @(negedge clk); k++; end
    chk("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (held) begin
        chk("hold_vld", out_valid, 1);
        chk("hold_imm", imm_ext, held_imm);
        chk("hold_typ", imm_type, held_typ);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", out_valid, 0);
        else begin
          e = sb.pop_front();
          chk("imm_ext", imm_ext, e.imm);
          chk("imm_type", imm_type, e.typ);
          chk("illegal", illegal, e.ill);
          chk("cnt_pre", illegal_cnt, exp_cnt);
          if (e.ill && exp_cnt < 3) exp_cnt++;
        end
      end
      held = out_valid && !out_ready;
      held_imm = imm_ext;
      held_typ = imm_type;
    end else held = 1'b0;
  end

  always @(posedge clk) begin
    #2 if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17,
                           7'h6F, 7'h67, 7'h73, 7'h33, 7'h0F, 7'h7F};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_imm", imm_ext, 0);
    chk("rst_type", imm_type, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_cnt", illegal_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1; out_ready = 1'b1;

    // latency: accepted at edge 1, visible after edge 2
    send(32'hFFF00093, 3'd0);
    chk("lat1", out_valid, 0);
    @(posedge clk); #1;
    chk("lat2", out_valid, 1);
    drain();

    send(32'hFE000EE3, 3'd0);
    send(32'h123452B7, 3'd0);
    send(32'h001000EF, 3'd0);
    send(32'h4030D093, 3'd0);
    send(32'h4030D093, 3'd1);
    send(32'hFE112C23, 3'd0);
    send(32'h00208033, 3'd0);
    send(32'hDEADBEEF, 3'd7);
    send(32'h80000017, 3'd0);
    drain();

    send(32'h0000007F, 3'd0);
    drain();
    chk("cnt_one", illegal_cnt, 1);
    repeat (4) send(32'h0000007F, 3'd0);
    drain();
    chk("cnt_sat", illegal_cnt, 3);

    // back-pressure: two accepted, third refused while stalled
    out_ready = 1'b0;
    send(32'h00500093, 3'd0);
    send(32'hFFB00113, 3'd0);
    instr = 32'h00100193; imm_src = 3'd0; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("full_rdy", in_ready, 0);
      chk("stall_imm", imm_ext, sb[0].imm);
      chk("stall_depth", sb.size(), 2);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    send(32'h00100193, 3'd0);
    send(32'h00200213, 3'd0);
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [31:0] r = $urandom;
      r[6:0] = ops[$urandom_range(0, 11)];
      send(r, ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #3 out_ready = 1'b1;
    drain();

    // reset with both stages holding illegal items
    out_ready = 1'b0;
    send(32'h0000007F, 3'd0);
    send(32'h0000007F, 3'd0);
    @(negedge clk);
    chk("pre_rst_full", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cnt = 0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_cnt", illegal_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_idle", out_valid, 0);
    send(32'h02A00513, 3'd0);
    drain();
    chk("post_rst_cnt", illegal_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined RV32I/RV64I immediate generator; successor to the single-cycle combinational sign-extend unit.
- Covers all immediate formats: I, I-shift, S, B, U and J. U-type keeps bit 31. Shift amounts are zero-extended.
- Width is parametrised. Valid/ready handshakes on both sides give back-pressure, and a saturating counter tracks illegal encodings.
- Sits between instruction fetch/decode and the ALU operand mux.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64 (64 widens shamt to instr[25:20]).
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  instr/imm_src valid.
- in_ready  out  1  block can accept this cycle.
- instr  in  32  raw instruction word.
- imm_src  in  3  0=auto-decode from opcode; 1=I, 2=S, 3=B, 4=U, 5=J, 6=I-shift, 7=zero.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- imm_ext  out  XLEN  extended immediate.
- imm_type  out  3  format actually applied (same encoding as imm_src; 0=NONE).
- illegal  out  1  auto-decode found an unsupported opcode.
- illegal_cnt  out  CNT_W  saturating count of illegal results delivered.

Behaviour:
- Reset (rst_n=0 at a clock edge): out_valid=0, imm_ext=0, imm_type=0, illegal=0, illegal_cnt=0, all stage valids=0. Reset wins over every other event, including items in flight; those items are discarded.
- Stage 1 (decode): registers instr and the resolved format.
  - Auto mode maps opcodes as follows:
    - 0x03, 0x67, 0x73 -> I.
    - 0x13 -> I-shift when funct3 is 001 or 101, else I.
    - 0x23 -> S.
    - 0x63 -> B; all funct3 values accepted.
    - 0x37, 0x17 -> U.
    - 0x6F -> J.
    - 0x33, 0x0F -> NONE (imm 0, legal).
    - Anything else -> NONE with illegal=1.
  - Forced modes never raise illegal.
- Stage 2 (extend): registers imm_ext, imm_type and illegal.
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U: sext({instr[31:12], 12'b0}).
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - I-shift: zero-extended instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64); funct7 bits are dropped.
  - sext replicates instr[31] up to XLEN.
- Latency: 2 cycles from input handshake to out_valid when there is no back-pressure. Throughput is 1 per cycle.
- Handshake rules:
  - A transfer happens when valid&&ready are both high at a clock edge.
  - out_valid, imm_ext, imm_type and illegal must hold stable while out_valid=1 and out_ready=0.
  - in_valid may drop without a transfer.
- Stall logic:
  - Stage 2 advances when !s2_valid || out_ready.
  - Stage 1 advances when !s1_valid || s2 advances.
  - in_ready = stage-1 advance. This ready chain is combinational; there are no bubbles when out_ready stays high.
- Pipe full (both stages valid, out_ready=0): in_ready=0. Exactly 2 items are held and none are dropped or duplicated. Order is preserved.
- Simultaneous output and input handshakes in the same cycle: both occur and occupancy is unchanged.
- illegal_cnt increments by 1 on each output handshake with illegal=1. It saturates at 2^CNT_W-1 and does not wrap.

Decomposition:
- Package imm_gen_pkg holds:
  - The imm_type_e enum (NONE, I, S, B, U, J, ISHIFT, ZERO).
  - Opcode constants (OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM, OP_REG, OP_FENCE).
- One combinational sub-module, imm_extract (instr, type -> XLEN immediate), is instantiated in stage 2.

Test Plan:
- addi x1,x0,-1: instr 0xFFF00093, auto, out_ready=1 -> 2 cycles later imm_ext 0xFFFFFFFF, type I, illegal 0.
- beq x0,x0,-4: instr 0xFE000EE3 -> imm_ext 0xFFFFFFFC, type B. lui x5,0x12345: 0x123452B7 -> 0x12345000, type U. jal x1,+2048: 0x001000EF -> 0x00000800, type J.
- srai x1,x1,3: 0x4030D093 -> imm_ext 0x00000003, type ISHIFT. With imm_src=1 forced on the same word -> 0x00000403, type I.
- Back-pressure: 4 back-to-back inputs with out_ready=0 for 5 cycles -> in_ready falls after 2 accepted. After release, outputs emerge in order with no loss, and outputs stay stable while stalled.
- Illegal: instr 0x0000007F, auto -> imm_ext 0, illegal 1, illegal_cnt 1 after the handshake. With CNT_W=2 and 5 illegals delivered -> count saturates at 3.
- Reset mid-flight: assert rst_n=0 for 1 cycle with both stages full -> next cycle out_valid 0 and illegal_cnt 0, in_ready 1, and the old items never appear.
